// File: rtl/ones_cnt_rr_sched.sv
// Round-robin scheduler sharing one start/rdy ones-counter among N_REQ requesters.
// Optional WAIT watchdog enabled by defining SCHED_TIMEOUT_EN.
module ones_cnt_rr_sched #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = $clog2(DATA_W + 1),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [CNT_W-1:0]          result,
  output logic                      err,
  output logic                      busy,
  output logic                      cnt_start,
  output logic [DATA_W-1:0]         cnt_data,
  input  logic                      cnt_rdy,
  input  logic [CNT_W-1:0]          cnt_value
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, sel, sel_nx;
  logic [IDX_W-1:0]   pick, cand;
  logic               found;
  logic               seen_low;
  logic               complete;
  logic               timeout;
  logic [N_REQ-1:0]   grant_nx, done_nx;
  logic               err_nx;
  logic [CNT_W-1:0]   result_nx;
  logic [DATA_W-1:0]  cnt_data_nx;

  // A high rdy only counts once a low has been seen since the start pulse.
  assign complete = cnt_rdy && seen_low;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;

  assign timeout = (state == WAIT) &&
                   (wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts WAIT cycles, cleared while entering WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd <= '0;
    else if (state == ISSUE)
      wd <= '0;
    else if (state == WAIT)
      wd <= wd + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // First set request at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    grant_nx    = '0;
    done_nx     = '0;
    err_nx      = 1'b0;
    result_nx   = result;
    cnt_data_nx = cnt_data;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx    = ISSUE;
          sel_nx      = pick;
          grant_nx    = N_REQ'(1) << pick;
          cnt_data_nx = req_data[pick*DATA_W +: DATA_W];
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (complete) begin
          state_nx  = RESP;
          result_nx = cnt_value;
          done_nx   = N_REQ'(1) << sel;
        end else if (timeout) begin
          state_nx  = RESP;
          result_nx = '0;
          done_nx   = N_REQ'(1) << sel;
          err_nx    = 1'b1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Registered outputs, selection, pointer and stale-rdy qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cnt_start <= 1'b0;
      result    <= '0;
      cnt_data  <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      seen_low  <= 1'b0;
    end else begin
      grant     <= grant_nx;
      done      <= done_nx;
      err       <= err_nx;
      busy      <= (state_nx != IDLE);
      cnt_start <= |grant_nx;
      result    <= result_nx;
      cnt_data  <= cnt_data_nx;
      sel       <= sel_nx;
      if (state == ISSUE)
        seen_low <= 1'b0;
      else if (state == WAIT && !cnt_rdy)
        seen_low <= 1'b1;
      if (state == RESP)
        rr_ptr <= (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_ones_cnt_rr_sched.sv
// Scoreboard bench for ones_cnt_rr_sched with a behavioural start/rdy ones-counter.
// Honours SCHED_TIMEOUT_EN for the watchdog scenario.
`timescale 1ns/1ps
module tb_ones_cnt_rr_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int L  = 9;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    grant, done;
  logic [CW-1:0]   result;
  logic            err, busy, cnt_start;
  logic [DW-1:0]   cnt_data;
  logic            cnt_rdy = 1'b1;
  logic [CW-1:0]   cnt_value = '0;

  ones_cnt_rr_sched #(
    .N_REQ(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .result(result), .err(err),
    .busy(busy), .cnt_start(cnt_start), .cnt_data(cnt_data),
    .cnt_rdy(cnt_rdy), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  // Behavioural counter: rdy drops on start, rises L edges later.
  int          k = 0;
  int          stale_k = 0;
  bit          stale_mode = 0;
  bit          never_mode = 0;
  logic [DW-1:0] op_data = '0;

  always @(posedge clk) begin
    if (cnt_start) begin
      op_data <= cnt_data;
      if (stale_mode) begin
        stale_k <= 3;
        k <= 0;
      end else begin
        cnt_rdy <= 1'b0;
        k <= L;
      end
    end else if (stale_k > 0) begin
      stale_k <= stale_k - 1;
      if (stale_k == 1) begin
        cnt_rdy <= 1'b0;
        k <= L;
      end
    end else if (k > 0) begin
      k <= k - 1;
      if (k == 1 && !never_mode) begin
        cnt_rdy <= 1'b1;
        cnt_value <= CW'($countones(op_data));
      end
    end
  end

  typedef struct {
    int          idx;
    logic [7:0]  data;
  } gexp_t;

  typedef struct {
    int  idx;
    int  res;
    bit  err;
    int  lat;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t g;
  dexp_t d;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gcyc = 0;
  int reraise_left = 0;
  logic [N-1:0] reraise_mask = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever grant or done is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 0 || done != 0)
        chk("no_overlap", 64'((grant != 0) && (done != 0)), 0);
      if (grant != 0 || cnt_start)
        chk("start_with_grant", 64'(cnt_start), 64'(grant != 0));
      if (grant != 0) begin
        if (gq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got %b expected none", grant);
        end else begin
          g = gq.pop_front();
          chk("grant", 64'(grant), 64'(1) << g.idx);
          chk("cnt_data", 64'(cnt_data), 64'(g.data));
          gcyc = cyc;
        end
      end
      if (done != 0) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got %b expected none", done);
        end else begin
          d = dq.pop_front();
          chk("done", 64'(done), 64'(1) << d.idx);
          chk("result", 64'(result), 64'(d.res));
          chk("err", 64'(err), 64'(d.err));
          if (d.lat >= 0)
            chk("latency", 64'(cyc - gcyc), 64'(d.lat));
        end
      end
    end
  end

  task automatic push_op(input int idx, input logic [7:0] data,
                         input int res, input bit e, input int lat);
    gexp_t ge;
    dexp_t de;
    ge.idx = idx;
    ge.data = data;
    de.idx = idx;
    de.res = res;
    de.err = e;
    de.lat = lat;
    gq.push_back(ge);
    dq.push_back(de);
  endtask

  task automatic set_data(input int idx, input logic [7:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  // Requesters drop on grant and optionally re-raise on done.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((dq.size() != 0 || gq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      req = req & ~grant;
      if ((done & reraise_mask) != 0 && reraise_left > 0) begin
        req = req | (done & reraise_mask);
        reraise_left--;
      end
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: timed out after %0d cycles", name, n);
    end
  endtask

  task automatic wait_grant(input string name, input int budget);
    int n = 0;
    while (grant == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    req = req & ~grant;
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: no grant within %0d cycles", name, n);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_start"}, 64'(cnt_start), 0);
    chk({tag, "_result"}, 64'(result), 0);
    chk({tag, "_cnt_data"}, 64'(cnt_data), 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single request, B5 has five ones.
    set_data(0, 8'hB5);
    push_op(0, 8'hB5, 5, 0, L + 2);
    req = 4'b0001;
    drain("t1", 200);

    // 2: all four at once, served 0..3.
    pulse_rst();
    req_data = {8'h81, 8'h0F, 8'h00, 8'hFF};
    push_op(0, 8'hFF, 8, 0, L + 2);
    push_op(1, 8'h00, 0, 0, L + 2);
    push_op(2, 8'h0F, 4, 0, L + 2);
    push_op(3, 8'h81, 2, 0, L + 2);
    req = 4'hF;
    drain("t2", 400);

    // 3: requesters 0 and 2 re-raise after done.
    set_data(0, 8'hC3);
    set_data(2, 8'h7F);
    push_op(0, 8'hC3, 4, 0, L + 2);
    push_op(2, 8'h7F, 7, 0, L + 2);
    push_op(0, 8'hC3, 4, 0, L + 2);
    push_op(2, 8'h7F, 7, 0, L + 2);
    reraise_mask = 4'b0101;
    reraise_left = 2;
    req = 4'b0101;
    drain("t3", 400);
    reraise_mask = '0;

    // 4: serve 1 (pointer moves to 2), then reset during 3's WAIT.
    set_data(1, 8'h3C);
    push_op(1, 8'h3C, 4, 0, L + 2);
    req = 4'b0010;
    drain("t4a", 200);
    set_data(3, 8'h99);
    g.idx = 3;
    g.data = 8'h99;
    gq.push_back(g);
    req = 4'b1000;
    wait_grant("t4b", 50);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    set_data(1, 8'h01);
    set_data(2, 8'h07);
    push_op(1, 8'h01, 1, 0, L + 2);
    push_op(2, 8'h07, 3, 0, L + 2);
    req = 4'b0110;
    rst = 1'b0;
    drain("t4c", 400);

    // 5: rdy stays high after start; stale value 3 must be ignored.
    stale_mode = 1;
    set_data(0, 8'hFE);
    push_op(0, 8'hFE, 7, 0, L + 5);
    req = 4'b0001;
    drain("t5", 200);
    stale_mode = 0;

    // 6: counter never completes.
    never_mode = 1;
    set_data(1, 8'h55);
`ifdef SCHED_TIMEOUT_EN
    push_op(1, 8'h55, 0, 1, TO + 1);
    req = 4'b0010;
    drain("t6", 300);
`else
    begin
      bit bad_busy;
      bit bad_err;
      bad_busy = 0;
      bad_err = 0;
      g.idx = 1;
      g.data = 8'h55;
      gq.push_back(g);
      req = 4'b0010;
      wait_grant("t6", 50);
      repeat (100) begin
        @(negedge clk);
        if (!busy) bad_busy = 1;
        if (err) bad_err = 1;
      end
      chk("hang_busy_dropped", 64'(bad_busy), 0);
      chk("hang_err_seen", 64'(bad_err), 0);
    end
`endif
    never_mode = 0;
    pulse_rst();
    repeat (2) @(negedge clk);
    chk("grant_queue_left", 64'(gq.size()), 0);
    chk("done_queue_left", 64'(dq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
